// File: rtl/frame_capture_pkg.sv
// rtl/frame_capture_pkg.sv - shared types and encodings for the frame capture buffer
// Purpose: capture FSM state type and quantise-mode encodings.
// Ports: none (package).
package frame_capture_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SOF  = 2'd1,
    CAPTURING = 2'd2,
    COMPLETE  = 2'd3
  } state_t;

  // Quantise modes; the unused encoding 3 behaves like QM_EQMAX.
  localparam logic [1:0] QM_EQMAX  = 2'd0;
  localparam logic [1:0] QM_THRESH = 2'd1;
  localparam logic [1:0] QM_TRUNC  = 2'd2;

endpackage

// File: rtl/frame_capture_buffer_if.sv
// rtl/frame_capture_buffer_if.sv - pixel stream and read port bundle
// Purpose: groups the pixel input handshake and the frame read port.
// Ports (master = pixel source / frame reader, slave = capture buffer):
//   x_valid, x_data, x_sof  master -> slave   pixel stream
//   x_ready                 slave  -> master  stream backpressure
//   rd_en, rd_addr          master -> slave   read request
//   rd_data, rd_valid       slave  -> master  registered read response
interface frame_capture_buffer_if #(
  parameter int IN_W    = 8,
  parameter int STORE_W = 1,
  parameter int AW      = 19
);

  logic               x_valid;
  logic               x_ready;
  logic [IN_W-1:0]    x_data;
  logic               x_sof;
  logic               rd_en;
  logic [AW-1:0]      rd_addr;
  logic [STORE_W-1:0] rd_data;
  logic               rd_valid;

  modport master (
    output x_valid, x_data, x_sof, rd_en, rd_addr,
    input  x_ready, rd_data, rd_valid
  );

  modport slave (
    input  x_valid, x_data, x_sof, rd_en, rd_addr,
    output x_ready, rd_data, rd_valid
  );

endinterface

// File: rtl/pingpong_bram.sv
// rtl/pingpong_bram.sv - two-bank memory, one write port, one registered read port
// Purpose: ping-pong frame storage; each port selects its bank independently.
// Ports:
//   clk, rst                  clock, synchronous active-high reset (read register only)
//   we, wr_bank, wr_addr, wr_data   write port
//   rd_en, rd_bank, rd_addr   read request
//   rd_data                   read data, valid one cycle after rd_en
module pingpong_bram #(
  parameter int DEPTH = 307200,
  parameter int W     = 1,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          wr_bank,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  input  logic          rd_bank,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] bank0 [DEPTH];
  logic [W-1:0] bank1 [DEPTH];

  always_ff @(posedge clk) begin
    if (we && !wr_bank) bank0[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (we && wr_bank) bank1[wr_addr] <= wr_data;
  end

  // Addresses past the end of the frame read as zero instead of aliasing.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      if ({1'b0, rd_addr} >= (AW+1)'(DEPTH)) rd_data <= '0;
      else if (rd_bank)                      rd_data <= bank1[rd_addr];
      else                                   rd_data <= bank0[rd_addr];
    end
  end

endmodule

// File: rtl/frame_capture_buffer.sv
// rtl/frame_capture_buffer.sv - double-buffered quantising frame capture stage
// Purpose: captures one frame of quantised pixels into the write bank while the
//   previous complete frame stays readable from the other bank.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   bus (slave)          pixel stream in, frame read port out
//   capture_trigger      start request, sampled in IDLE
//   continuous           re-arm after every frame
//   mode, threshold      quantiser settings, latched on each start-of-frame
//   valid_to_read        read bank holds a complete frame
//   capture_complete     one-cycle pulse when a frame is finished
//   capturing            waiting for or receiving a frame
//   frame_error          one-cycle pulse after a restart by an early x_sof
module frame_capture_buffer
  import frame_capture_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int IN_W       = 8,
  parameter int STORE_W    = 1
) (
  input  logic            clk,
  input  logic            rst,
  frame_capture_buffer_if.slave bus,
  input  logic            capture_trigger,
  input  logic            continuous,
  input  logic [1:0]      mode,
  input  logic [IN_W-1:0] threshold,
  output logic            valid_to_read,
  output logic            capture_complete,
  output logic            capturing,
  output logic            frame_error
);

  localparam int TOTAL_PIXELS = IMG_WIDTH * IMG_HEIGHT;
  localparam int AW           = $clog2(TOTAL_PIXELS);
  localparam logic [AW-1:0] LAST_ADDR = AW'(TOTAL_PIXELS - 1);

  state_t             state_q, state_d;
  logic [AW-1:0]      wr_addr_q, wr_addr_d;
  logic               wr_bank_q, wr_bank_d;
  logic               rd_bank_q, rd_bank_d;
  logic [1:0]         mode_q, mode_d;
  logic [IN_W-1:0]    thr_q, thr_d;
  logic               valid_to_read_d;
  logic               frame_error_d;
  logic               rd_valid_q;

  logic               handshake;
  logic               wr_en;
  logic [AW-1:0]      wr_ptr;
  logic [1:0]         eff_mode;
  logic [IN_W-1:0]    eff_thr;
  logic [STORE_W-1:0] wr_data;

  assign bus.x_ready      = (state_q == WAIT_SOF) || (state_q == CAPTURING);
  assign capturing        = bus.x_ready;
  assign capture_complete = (state_q == COMPLETE);
  assign bus.rd_valid     = rd_valid_q;

  assign handshake = bus.x_valid & bus.x_ready;

  // An SOF pixel always lands at address 0 and is quantised with the settings
  // latched alongside it; later pixels use the frozen per-frame settings.
  assign wr_ptr   = bus.x_sof ? '0 : wr_addr_q;
  assign eff_mode = bus.x_sof ? mode : mode_q;
  assign eff_thr  = bus.x_sof ? threshold : thr_q;
  // Pixels before the first SOF are accepted and discarded.
  assign wr_en    = handshake & (bus.x_sof | (state_q == CAPTURING));

  always_comb begin
    wr_data = '0;
    case (eff_mode)
      QM_THRESH: wr_data = (bus.x_data >= eff_thr) ? '1 : '0;
      QM_TRUNC:  wr_data = bus.x_data[IN_W-1 -: STORE_W];
      default:   wr_data = (bus.x_data == '1) ? '1 : '0;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    wr_addr_d       = wr_addr_q;
    wr_bank_d       = wr_bank_q;
    rd_bank_d       = rd_bank_q;
    mode_d          = mode_q;
    thr_d           = thr_q;
    valid_to_read_d = valid_to_read;
    frame_error_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture_trigger) state_d = WAIT_SOF;
      end
      WAIT_SOF, CAPTURING: begin
        if (wr_en) begin
          if (bus.x_sof) begin
            mode_d        = mode;
            thr_d         = threshold;
            frame_error_d = (state_q == CAPTURING);
          end
          if (wr_ptr == LAST_ADDR) begin
            wr_addr_d = '0;
            state_d   = COMPLETE;
          end else begin
            wr_addr_d = wr_ptr + AW'(1);
            state_d   = CAPTURING;
          end
        end
      end
      COMPLETE: begin
        rd_bank_d       = wr_bank_q;
        wr_bank_d       = ~wr_bank_q;
        valid_to_read_d = 1'b1;
        state_d         = continuous ? WAIT_SOF : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_addr_q     <= '0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b1;
      mode_q        <= QM_EQMAX;
      thr_q         <= '0;
      valid_to_read <= 1'b0;
      frame_error   <= 1'b0;
      rd_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      mode_q        <= mode_d;
      thr_q         <= thr_d;
      valid_to_read <= valid_to_read_d;
      frame_error   <= frame_error_d;
      rd_valid_q    <= bus.rd_en;
    end
  end

  pingpong_bram #(
    .DEPTH (TOTAL_PIXELS),
    .W     (STORE_W),
    .AW    (AW)
  ) u_bram (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en),
    .wr_bank (wr_bank_q),
    .wr_addr (wr_ptr),
    .wr_data (wr_data),
    .rd_en   (bus.rd_en),
    .rd_bank (rd_bank_q),
    .rd_addr (bus.rd_addr),
    .rd_data (bus.rd_data)
  );

endmodule

// File: tb/tb_frame_capture_buffer.sv
// tb/tb_frame_capture_buffer.sv - self-checking bench for frame_capture_buffer
module tb_frame_capture_buffer;
  import frame_capture_pkg::*;

  localparam int TP = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, x_valid, x_sof, capture_trigger, continuous, rd_en, rd3_en;
  logic [7:0] x_data, threshold;
  logic [1:0] mode;
  logic [2:0] rd_addr, rd3_addr;
  logic       vtr1, cc1, cap1, fe1;
  logic       vtr4, cc4, cap4, fe4;
  logic       vtr3, cc3, cap3, fe3;

  frame_capture_buffer_if #(.IN_W(8), .STORE_W(1), .AW(3)) b1 ();
  frame_capture_buffer_if #(.IN_W(8), .STORE_W(4), .AW(3)) b4 ();
  frame_capture_buffer_if #(.IN_W(8), .STORE_W(1), .AW(3)) b3 ();

  assign b1.x_valid = x_valid;  assign b4.x_valid = x_valid;  assign b3.x_valid = 1'b0;
  assign b1.x_data  = x_data;   assign b4.x_data  = x_data;   assign b3.x_data  = 8'h00;
  assign b1.x_sof   = x_sof;    assign b4.x_sof   = x_sof;    assign b3.x_sof   = 1'b0;
  assign b1.rd_en   = rd_en;    assign b4.rd_en   = rd_en;    assign b3.rd_en   = rd3_en;
  assign b1.rd_addr = rd_addr;  assign b4.rd_addr = rd_addr;  assign b3.rd_addr = rd3_addr;

  frame_capture_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .IN_W(8), .STORE_W(1)) dut1 (
    .clk(clk), .rst(rst), .bus(b1), .capture_trigger(capture_trigger),
    .continuous(continuous), .mode(mode), .threshold(threshold),
    .valid_to_read(vtr1), .capture_complete(cc1), .capturing(cap1), .frame_error(fe1));

  frame_capture_buffer #(.IMG_WIDTH(4), .IMG_HEIGHT(2), .IN_W(8), .STORE_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(b4), .capture_trigger(capture_trigger),
    .continuous(continuous), .mode(mode), .threshold(threshold),
    .valid_to_read(vtr4), .capture_complete(cc4), .capturing(cap4), .frame_error(fe4));

  // 5-pixel frame so that read addresses 5..7 fall past the end.
  frame_capture_buffer #(.IMG_WIDTH(5), .IMG_HEIGHT(1), .IN_W(8), .STORE_W(1)) dut3 (
    .clk(clk), .rst(rst), .bus(b3), .capture_trigger(1'b0),
    .continuous(1'b0), .mode(2'd0), .threshold(8'd0),
    .valid_to_read(vtr3), .capture_complete(cc3), .capturing(cap3), .frame_error(fe3));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks whether a frame is armed / being received as a
  // queue of raw pixels, and the frame visible to readers as plain arrays.
  bit m_wait, m_infr, m_fin, m_vtr, m_fe, m_rdv, m_rd_known, shown_known;
  int m_rd1, m_rd4, f_mode, f_thr;
  int fq[$];
  int shown1[TP];
  int shown4[TP];

  function automatic int quant(input int px, input int md, input int thr, input int sw);
    int ones = (1 << sw) - 1;
    case (md)
      1:       return (px >= thr) ? ones : 0;
      2:       return px / (1 << (8 - sw));
      default: return (px == 255) ? ones : 0;
    endcase
  endfunction

  task automatic model_step();
    if (rst) begin
      m_wait = 0; m_infr = 0; m_fin = 0; m_vtr = 0; m_fe = 0; m_rdv = 0;
      m_rd1 = 0; m_rd4 = 0; m_rd_known = 1; shown_known = 0;
      fq.delete();
      return;
    end
    m_rdv = rd_en;
    if (rd_en) begin
      m_rd_known = shown_known;
      m_rd1 = shown1[rd_addr];
      m_rd4 = shown4[rd_addr];
    end
    m_fe = 0;
    if (m_fin) begin
      for (int i = 0; i < TP; i++) begin
        shown1[i] = quant(fq[i], f_mode, f_thr, 1);
        shown4[i] = quant(fq[i], f_mode, f_thr, 4);
      end
      shown_known = 1; m_vtr = 1; m_fin = 0; m_wait = continuous;
      fq.delete();
    end else if (!m_wait && !m_infr) begin
      if (capture_trigger) m_wait = 1;
    end else if (x_valid) begin
      if (x_sof) begin
        if (m_infr) m_fe = 1;
        fq.delete();
        fq.push_back(int'(x_data));
        f_mode = int'(mode); f_thr = int'(threshold);
        m_infr = 1; m_wait = 0;
      end else if (m_infr) begin
        fq.push_back(int'(x_data));
      end
      if (m_infr && fq.size() == TP) begin
        m_infr = 0; m_fin = 1;
      end
    end
  endtask

  task automatic check_outputs();
    bit rdy;
    rdy = m_wait | m_infr;
    chk("x_ready_1", b1.x_ready, rdy);          chk("x_ready_4", b4.x_ready, rdy);
    chk("capturing_1", cap1, rdy);              chk("capturing_4", cap4, rdy);
    chk("capture_complete_1", cc1, m_fin);      chk("capture_complete_4", cc4, m_fin);
    chk("valid_to_read_1", vtr1, m_vtr);        chk("valid_to_read_4", vtr4, m_vtr);
    chk("frame_error_1", fe1, m_fe);            chk("frame_error_4", fe4, m_fe);
    chk("rd_valid_1", b1.rd_valid, m_rdv);      chk("rd_valid_4", b4.rd_valid, m_rdv);
    if (m_rd_known) begin
      chk("rd_data_1", b1.rd_data, m_rd1);
      chk("rd_data_4", b4.rd_data, m_rd4);
    end
  endtask

  task automatic cycle();
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    x_valid = 0; x_sof = 0; capture_trigger = 0; rd_en = 0;
  endtask

  task automatic rand_rd();
    rd_en   = 1'($urandom);
    rd_addr = 3'($urandom);
  endtask

  task automatic wait_complete(input string name, input int budget);
    bit seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      seen = cc1;
      cycle();
    end
    chk(name, seen, 1);
  endtask

  task automatic trigger();
    capture_trigger = 1;
    cycle();
    capture_trigger = 0;
  endtask

  task automatic send_frame(input bit gaps, input int cont_off_at);
    for (int i = 0; i < TP; i++) begin
      if (gaps)
        for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
          x_valid = 0; x_sof = 0; rand_rd(); cycle();
        end
      x_valid = 1; x_sof = (i == 0); x_data = 8'($urandom); rand_rd();
      if (i == cont_off_at) continuous = 0;
      cycle();
    end
    x_valid = 0; x_sof = 0;
  endtask

  typedef struct {
    logic [1:0]      mode;
    logic [7:0]      thr;
    logic [0:7][7:0] pix;
    logic [0:7]      e1;
    logic [0:7][3:0] e4;
  } vec_t;
  vec_t vec [4];

  task automatic set_vec(input int k, input logic [1:0] m, input logic [7:0] t,
                         input logic [63:0] p, input logic [7:0] e1, input logic [31:0] e4);
    vec[k].mode = m; vec[k].thr = t; vec[k].pix = p; vec[k].e1 = e1; vec[k].e4 = e4;
  endtask

  initial begin
    set_vec(0, QM_EQMAX,  8'd0,   64'hFF00_FF00_0000_00FF, 8'b1010_0001, 32'hF0F0_000F);
    set_vec(1, QM_THRESH, 8'd128, 64'h7F80_C800_FF81_0180, 8'b0110_1101, 32'h0FF0_FF0F);
    set_vec(2, QM_TRUNC,  8'd0,   64'hA700_FF80_7F10_5CE3, 8'b1011_0001, 32'hA0F8_715E);
    set_vec(3, 2'd3,      8'd0,   64'hFFFE_FF01_00FF_FF80, 8'b1010_0110, 32'hF0F0_0FF0);

    rst = 1; x_valid = 0; x_sof = 0; x_data = 0; capture_trigger = 0; continuous = 0;
    mode = 0; threshold = 0; rd_en = 0; rd_addr = 0; rd3_en = 0; rd3_addr = 0;
    repeat (2) @(posedge clk);
    #1;
    model_step();
    cycle();
    rst = 0;
    cycle();

    // Single-shot frames from the table; settings are disturbed after SOF.
    for (int v = 0; v < 4; v++) begin
      idle_inputs(); continuous = 0; mode = vec[v].mode; threshold = vec[v].thr;
      trigger();
      for (int i = 0; i < TP; i++) begin
        x_valid = 1; x_data = vec[v].pix[i]; x_sof = (i == 0);
        cycle();
        if (i == 0) begin mode = mode + 2'd1; threshold = 8'($urandom); end
      end
      idle_inputs();
      wait_complete("table_complete", 6);
      for (int i = 0; i < TP; i++) begin
        rd_en = 1; rd_addr = 3'(i);
        cycle();
        chk("table_rd_data_1", b1.rd_data, vec[v].e1[i]);
        chk("table_rd_data_4", b4.rd_data, vec[v].e4[i]);
      end
      rd_en = 0;
      cycle();
      chk("table_idle_ready", b1.x_ready, 0);
    end

    // Pixels before SOF are dropped; frame arrives with random gaps.
    idle_inputs(); mode = 2'($urandom); threshold = 8'($urandom);
    trigger();
    for (int i = 0; i < 3; i++) begin
      x_valid = 1; x_sof = 0; x_data = 8'($urandom); rand_rd(); cycle();
    end
    send_frame(1, -1);
    wait_complete("presof_complete", 6);

    // Continuous ping-pong: A, B, then C with continuous dropped mid-frame.
    continuous = 1; mode = 2'd2; threshold = 8'($urandom);
    trigger();
    send_frame(1, -1);
    wait_complete("cont_a_complete", 6);
    mode = 2'd1; threshold = 8'($urandom);
    send_frame(1, -1);
    wait_complete("cont_b_complete", 6);
    mode = 2'($urandom);
    send_frame(1, 3);
    wait_complete("cont_c_complete", 6);
    for (int i = 0; i < TP; i++) begin rd_en = 1; rd_addr = 3'(i); cycle(); end
    rd_en = 0;
    chk("cont_stop_idle", b1.x_ready, 0);

    // Early SOF at pixel 5 restarts the frame.
    idle_inputs(); mode = 2'd2;
    trigger();
    for (int i = 0; i < 5; i++) begin
      x_valid = 1; x_sof = (i == 0); x_data = 8'($urandom); cycle();
    end
    x_sof = 1; x_data = 8'($urandom); cycle();
    chk("early_sof_error_1", fe1, 1);
    chk("early_sof_error_4", fe4, 1);
    for (int i = 0; i < 7; i++) begin
      chk("early_sof_no_complete", cc1, 0);
      x_valid = 1; x_sof = 0; x_data = 8'($urandom); cycle();
    end
    idle_inputs();
    wait_complete("early_sof_complete", 6);

    // Reset in the middle of a frame, then a clean frame.
    trigger();
    for (int i = 0; i < 4; i++) begin
      x_valid = 1; x_sof = (i == 0); x_data = 8'($urandom); cycle();
    end
    rst = 1; cycle();
    rst = 0; idle_inputs(); cycle();
    chk("midreset_vtr", vtr1, 0);
    chk("midreset_ready", b1.x_ready, 0);
    trigger();
    send_frame(0, -1);
    wait_complete("post_reset_complete", 6);
    chk("post_reset_vtr", vtr1, 1);

    // Random soak against the model.
    for (int c = 0; c < 800; c++) begin
      rst             = ($urandom_range(0, 299) == 0);
      capture_trigger = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 39) == 0) continuous = 1'($urandom);
      x_valid   = 1'($urandom);
      x_sof     = ($urandom_range(0, 11) == 0);
      x_data    = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      mode      = 2'($urandom);
      threshold = 8'($urandom);
      rand_rd();
      cycle();
    end
    rst = 0; idle_inputs(); continuous = 0;
    cycle();

    // Out-of-range reads on the 5-pixel instance.
    for (int a = 5; a < 8; a++) begin
      rd3_en = 1; rd3_addr = 3'(a);
      cycle();
      chk("oob_rd_valid", b3.rd_valid, 1);
      chk("oob_rd_data", b3.rd_data, 0);
    end
    rd3_en = 0;
    cycle();
    chk("oob_rd_valid_off", b3.rd_valid, 0);
    chk("oob_idle_outputs", {b3.x_ready, cap3, cc3, fe3, vtr3}, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/frame_capture_buffer.md
Name: frame_capture_buffer

Overview:
Parametrised, double-buffered frame capture stage for the pattern-recognition pipeline. It accepts a valid/ready pixel stream with a start-of-frame marker and quantises each pixel by a runtime-selectable mode into STORE_W bits. It writes one frame into the write bank of a ping-pong BRAM pair while downstream logic reads the last completed frame from the other bank. Supports single-shot and continuous capture.

Parameters:
IMG_WIDTH, 640, pixels per line
IMG_HEIGHT, 480, lines per frame
IN_W, 8, input pixel width
STORE_W, 1, stored bits per pixel (1..IN_W)
Localparams: TOTAL_PIXELS = IMG_WIDTH*IMG_HEIGHT; AW = $clog2(TOTAL_PIXELS)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
x_valid  in  1  input pixel valid
x_ready  out  1  input ready
x_data  in  IN_W  input pixel
x_sof  in  1  pixel is first of frame (qualified by handshake)
capture_trigger  in  1  start request (level sampled when IDLE)
continuous  in  1  1 = re-arm automatically after each frame
mode  in  2  quantise mode: 0 = equal-to-max, 1 = threshold, 2 = truncate, 3 = reserved (acts as 0)
threshold  in  IN_W  threshold for mode 1
rd_en  in  1  read request
rd_addr  in  AW  read pixel address (row-major)
rd_data  out  STORE_W  read data
rd_valid  out  1  rd_data valid
valid_to_read  out  1  read bank holds a complete frame
capture_complete  out  1  one-cycle pulse at frame completion
capturing  out  1  high in WAIT_SOF or CAPTURING
frame_error  out  1  one-cycle pulse on early x_sof (frame restart)

Behaviour:
- Reset: state=IDLE, wr_addr=0, wr_bank=0, rd_bank=1. All outputs 0. Memory contents are not cleared. A reset mid-frame abandons the frame; valid_to_read drops to 0.
- handshake = x_valid & x_ready. x_ready = (state==WAIT_SOF || state==CAPTURING), combinational from state.
- IDLE: capture_trigger=1 -> WAIT_SOF. Trigger in any other state is ignored.
- WAIT_SOF: handshake without x_sof -> pixel is dropped. Handshake with x_sof -> latch mode/threshold, write the pixel at addr 0, wr_addr<=1, go to CAPTURING.
- CAPTURING: each handshake writes mem[wr_bank][wr_addr] and increments wr_addr.
  - Handshake with x_sof -> frame_error pulse next cycle, write at addr 0, wr_addr<=1, re-latch mode/threshold.
  - Handshake at wr_addr==TOTAL_PIXELS-1 -> wr_addr<=0, go to COMPLETE.
- COMPLETE (one cycle, x_ready=0):
  - Swap banks: rd_bank<=wr_bank, wr_bank<=~wr_bank.
  - capture_complete=1 for this cycle only.
  - valid_to_read<=1, held until reset.
  - Next state: WAIT_SOF if continuous=1, else IDLE.
- Deasserting continuous mid-frame: the current frame completes, then the block goes to IDLE.
- mode and threshold are frozen per frame. Changes mid-frame take effect at the next SOF.
- Quantise:
  - mode 0: all-ones if x_data == 2^IN_W-1, else 0.
  - mode 1: all-ones if x_data >= threshold, else 0.
  - mode 2: x_data[IN_W-1 -: STORE_W].
- Read port:
  - rd_data and rd_valid are registered, 1-cycle latency after rd_en.
  - Reads come from rd_bank as sampled in the rd_en cycle. A read in the COMPLETE cycle returns the old bank.
  - rd_addr >= TOTAL_PIXELS returns 0, with rd_valid still 1.
  - rd_valid=0 when rd_en=0.
  - Reads are allowed regardless of valid_to_read; data is undefined before the first frame.
- Read and write never target the same bank concurrently, so no collision logic is required.

Decomposition:
- Package frame_capture_pkg: state_t enum {IDLE, WAIT_SOF, CAPTURING, COMPLETE}; mode encodings QM_EQMAX=0, QM_THRESH=1, QM_TRUNC=2.
- Sub-module pingpong_bram #(DEPTH, W): two banks with one write port and one registered read port, each taking a bank-select input. Inferable as BRAM.
- FSM, quantiser and counters live in the top module.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=2, STORE_W=1 unless stated):
- Single-shot, mode 0: trigger, then pixels 255,0,255,0,0,0,0,255 (SOF on first) -> capture_complete one pulse; valid_to_read=1; reading addrs 0..7 gives 1,0,1,0,0,0,0,1 with 1-cycle latency; state IDLE; x_ready=0.
- Pre-SOF drop and backpressure: trigger, send 3 pixels without SOF, then a frame with random x_valid gaps -> the 3 pixels are discarded; frame stored exactly once; no pixel lost or duplicated.
- Mode 1 with threshold=128: inputs 127,128,200,0,... -> stored 0,1,1,0. Mode 2 with STORE_W=4: x_data 8'hA7 stored as 4'hA.
- Continuous ping-pong: continuous=1, two frames A then B -> after A, reads return A while B is written; after B's capture_complete, reads return B; rd_bank toggles each frame.
- Early SOF: SOF again at pixel 5 -> frame_error pulse; capture restarts at addr 0; completion occurs only after 8 further pixels.
- Reset mid-frame: assert rst at pixel 4 -> next cycle all outputs 0 and state IDLE; a new trigger and full frame complete normally.
